// File: rtl/uart_pkg.sv
// Shared UART definitions: string-controller state encoding and baud codes
// understood by uart_byte_tx.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StFetch = 3'd1,
        StSend  = 3'd2,
        StWait  = 3'd3,
        StGap   = 3'd4,
        StFin   = 3'd5
    } str_state_e;

    localparam logic [2:0] Baud9600   = 3'd0;
    localparam logic [2:0] Baud19200  = 3'd1;
    localparam logic [2:0] Baud38400  = 3'd2;
    localparam logic [2:0] Baud57600  = 3'd3;
    localparam logic [2:0] Baud115200 = 3'd4;

endpackage

// File: rtl/uart_str_buf.sv
// String buffer: DEPTH x 8 storage, one synchronous write port and one
// registered read port whose output holds between reads.
module uart_str_buf #(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= 8'h00;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/uart_str_ctrl.sv
// Streams a byte string from a local buffer to an external uart_byte_tx,
// one byte per send/tx_done handshake, with optional inter-byte gap and abort.
module uart_str_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned GAP_CYCLES = 0,
    localparam int unsigned AW        = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW:0]   str_len,
    input  logic [2:0]    baud_sel,
    input  logic          start,
    input  logic          abort,
    input  logic          tx_done,
    output logic [7:0]    tx_data,
    output logic          tx_send_en,
    output logic [2:0]    tx_baud_set,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] byte_idx
);

    localparam int unsigned GW = $clog2(GAP_CYCLES + 2);
    localparam logic [GW-1:0] GapLast = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [AW:0] DepthLen = (AW + 1)'(DEPTH);

    str_state_e      state_q;
    logic [AW:0]     len_q;
    logic [GW-1:0]   gap_cnt_q;
    logic            abort_q;

    logic [AW:0]     len_in;
    logic            abort_pend;
    logic            is_last;
    logic            buf_wr;
    logic            buf_rd;

    assign len_in     = (str_len > DepthLen) ? DepthLen : str_len;
    assign abort_pend = abort_q | abort;
    assign is_last    = ({1'b0, byte_idx} == (len_q - 1'b1));
    // Buffer is frozen for the whole transfer, including the post-FIN cycle.
    assign buf_wr     = wr_en & ~busy;
    assign buf_rd     = (state_q == StFetch) & ~abort_pend;

    uart_str_buf #(
        .DEPTH (DEPTH)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (buf_wr),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (buf_rd),
        .rd_addr (byte_idx),
        .rd_data (tx_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            len_q       <= '0;
            gap_cnt_q   <= '0;
            abort_q     <= 1'b0;
            tx_send_en  <= 1'b0;
            tx_baud_set <= Baud9600;
            busy        <= 1'b0;
            done        <= 1'b0;
            byte_idx    <= '0;
        end else begin
            tx_send_en <= 1'b0;
            done       <= 1'b0;
            if (abort) begin
                abort_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    busy    <= 1'b0;
                    abort_q <= 1'b0;
                    if (start && !busy) begin
                        len_q       <= len_in;
                        tx_baud_set <= baud_sel;
                        byte_idx    <= '0;
                        busy        <= 1'b1;
                        state_q     <= (len_in == '0) ? StFin : StFetch;
                    end
                end
                StFetch: begin
                    if (abort_pend) begin
                        state_q <= StFin;
                    end else begin
                        tx_send_en <= 1'b1;
                        state_q    <= StSend;
                    end
                end
                StSend: begin
                    state_q <= StWait;
                end
                StWait: begin
                    if (tx_done) begin
                        if (is_last || abort_pend) begin
                            state_q <= StFin;
                        end else begin
                            byte_idx  <= byte_idx + AW'(1);
                            gap_cnt_q <= '0;
                            state_q   <= (GAP_CYCLES == 0) ? StFetch : StGap;
                        end
                    end
                end
                StGap: begin
                    if (abort_pend) begin
                        state_q <= StFin;
                    end else if (gap_cnt_q == GapLast) begin
                        gap_cnt_q <= '0;
                        state_q   <= StFetch;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GW'(1);
                    end
                end
                StFin: begin
                    done    <= 1'b1;
                    abort_q <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_str_ctrl.sv
// Scoreboard bench for uart_str_ctrl with a behavioural uart_byte_tx responder.
module tb_uart_str_ctrl;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned GAP   = 2;
    localparam int unsigned AW    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [7:0]    wr_data = '0;
    logic [AW:0]   str_len = '0;
    logic [2:0]    baud_sel = '0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          tx_done = 1'b0;
    logic [7:0]    tx_data;
    logic          tx_send_en;
    logic [2:0]    tx_baud_set;
    logic          busy;
    logic          done;
    logic [AW-1:0] byte_idx;

    always #10 clk = ~clk;  // 50 MHz

    uart_str_ctrl #(
        .DEPTH      (DEPTH),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .str_len     (str_len),
        .baud_sel    (baud_sel),
        .start       (start),
        .abort       (abort),
        .tx_done     (tx_done),
        .tx_data     (tx_data),
        .tx_send_en  (tx_send_en),
        .tx_baud_set (tx_baud_set),
        .busy        (busy),
        .done        (done),
        .byte_idx    (byte_idx)
    );

    typedef struct {
        logic [7:0] data;
        logic [2:0] baud;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] model_mem [DEPTH];
    int         n_checks = 0;
    int         n_pass = 0;
    int         done_pending = 0;
    int         sends = 0;
    int         gen = 0;
    int         s0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    endtask

    // Monitor: every send pulse must match the next expected byte.
    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_send_en) begin
                sends++;
                check("send_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("tx_data", 32'(tx_data), 32'(e.data));
                    check("tx_baud_set", 32'(tx_baud_set), 32'(e.baud));
                end
            end
            if (done) begin
                check("done_expected", 32'(done_pending != 0), 1);
                if (done_pending != 0) done_pending--;
                check("busy_with_done", 32'(busy), 1);
            end
        end
    end

    // Responder standing in for uart_byte_tx; sometimes stretches tx_done
    // into the following (non-WAIT) cycle, which the DUT must ignore.
    logic [7:0] rsp_d;
    logic [2:0] rsp_b;
    int         rsp_g;
    always begin
        @(negedge clk);
        if (rst_n && tx_send_en) begin
            rsp_d = tx_data;
            rsp_b = tx_baud_set;
            rsp_g = gen;
            repeat ($urandom_range(3, 8)) @(posedge clk);
            #1;
            if (rsp_g == gen && rst_n) begin
                check("tx_data_stable", 32'(tx_data), 32'(rsp_d));
                check("baud_stable", 32'(tx_baud_set), 32'(rsp_b));
                tx_done = 1'b1;
                @(posedge clk);
                #1;
                if ($urandom_range(0, 1) == 1) begin
                    @(posedge clk);
                    #1;
                end
                tx_done = 1'b0;
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        wr_en = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        tick();
        wr_en = 1'b0;
        model_mem[a] = d;
    endtask

    // Issue start (optionally with a same-cycle write) and queue the expected bytes.
    task automatic go(input int len, input logic [2:0] b, input bit do_wr = 0,
                      input int a = 0, input logic [7:0] d = 8'h00);
        int n;
        if (do_wr) begin
            wr_en = 1'b1;
            wr_addr = AW'(a);
            wr_data = d;
            model_mem[a] = d;
        end
        str_len = (AW + 1)'(len);
        baud_sel = b;
        start = 1'b1;
        n = (len > int'(DEPTH)) ? int'(DEPTH) : len;
        for (int i = 0; i < n; i++) exp_q.push_back('{data: model_mem[i], baud: b});
        done_pending++;
        tick();
        start = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while ((done_pending != 0 || busy) && t < 3000) begin
            tick();
            t++;
        end
        check({name, "_timeout"}, 32'(t < 3000), 1);
        tick(10);
        check({name, "_drained"}, 32'(exp_q.size()), 0);
    endtask

    task automatic wait_sends(input int target, input string name);
        int t = 0;
        while ((sends - s0) < target && t < 2000) begin
            tick();
            t++;
        end
        check({name, "_reach"}, 32'(t < 2000), 1);
    endtask

    task automatic check_reset(input string name);
        check({name, "_busy"}, 32'(busy), 0);
        check({name, "_done"}, 32'(done), 0);
        check({name, "_send_en"}, 32'(tx_send_en), 0);
        check({name, "_tx_data"}, 32'(tx_data), 0);
        check({name, "_baud"}, 32'(tx_baud_set), 0);
        check({name, "_byte_idx"}, 32'(byte_idx), 0);
    endtask

    initial begin
        #35;
        check_reset("reset");
        rst_n = 1'b1;
        tick(2);

        // "HELLO"
        s0 = sends;
        wr(0, 8'h48); wr(1, 8'h45); wr(2, 8'h4C); wr(3, 8'h4C); wr(4, 8'h4F);
        go(5, 3'd0);
        wait_idle("hello");
        check("hello_sends", 32'(sends - s0), 5);

        for (int i = 0; i < int'(DEPTH); i++) wr(i, 8'($urandom));

        // Zero length: done two clocks after start, no sends.
        s0 = sends;
        go(0, 3'd3);
        check("len0_busy_c1", 32'(busy), 1);
        check("len0_done_c1", 32'(done), 0);
        tick();
        check("len0_busy_c2", 32'(busy), 1);
        check("len0_done_c2", 32'(done), 1);
        tick();
        check("len0_busy_c3", 32'(busy), 0);
        check("len0_done_c3", 32'(done), 0);
        check("len0_sends", 32'(sends - s0), 0);

        // Random transfers, half with a write in the start cycle.
        for (int k = 0; k < 6; k++) begin
            int len;
            len = $urandom_range(1, DEPTH);
            s0 = sends;
            go(len, 3'($urandom_range(0, 4)), bit'($urandom_range(0, 1)),
               $urandom_range(0, len - 1), 8'($urandom));
            wait_idle("rand");
            check("rand_sends", 32'(sends - s0), 32'(len));
        end

        // Over-length clamps to DEPTH.
        s0 = sends;
        go(20, 3'd1);
        wait_idle("clamp");
        check("clamp_sends", 32'(sends - s0), DEPTH);
        check("clamp_idx_hold", 32'(byte_idx), DEPTH - 1);
        go(2, 3'd1);
        check("next_idx_zero", 32'(byte_idx), 0);
        wait_idle("after_clamp");

        // Abort while byte 2 is on the line.
        s0 = sends;
        go(5, 3'd2);
        wait_sends(3, "abort");
        abort = 1'b1;
        exp_q.delete();
        tick();
        abort = 1'b0;
        wait_idle("abort");
        check("abort_sends", 32'(sends - s0), 3);

        // start and wr_en during a transfer are ignored.
        s0 = sends;
        go(8, 3'd4);
        wait_sends(2, "busy_ign");
        wr_en = 1'b1;
        wr_addr = '0;
        wr_data = ~model_mem[0];
        str_len = 5'd3;
        start = 1'b1;
        tick();
        wr_en = 1'b0;
        start = 1'b0;
        wait_idle("busy_ign");
        check("busy_ign_sends", 32'(sends - s0), 8);
        s0 = sends;
        go(8, 3'd4);
        wait_idle("readback");
        check("readback_sends", 32'(sends - s0), 8);

        // Reset during WAIT of byte 1.
        s0 = sends;
        go(6, 3'd5);
        wait_sends(2, "rst_mid");
        #3;
        rst_n = 1'b0;
        gen++;
        exp_q.delete();
        done_pending = 0;
        #1;
        check_reset("rst_mid");
        tick(3);
        rst_n = 1'b1;
        tick(2);
        s0 = sends;
        go(4, 3'd6);
        check("rst_restart_idx", 32'(byte_idx), 0);
        wait_idle("rst_restart");
        check("rst_restart_sends", 32'(sends - s0), 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_str_ctrl.md
UART_STR_CTRL -- requirements
Module: uart_str_ctrl

Interface
REQ-001 Parameter DEPTH, 16, string buffer depth in bytes (power of two, 2..256).
REQ-002 Parameter GAP_CYCLES, 0, idle clk cycles inserted between consecutive bytes.
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 wr_en  in  1  buffer write strobe.
REQ-006 wr_addr  in  log2(DEPTH)  buffer write address.
REQ-007 wr_data  in  8  buffer write byte.
REQ-008 str_len  in  log2(DEPTH)+1  bytes to send, sampled on start.
REQ-009 baud_sel  in  3  baud code, sampled on start.
REQ-010 start  in  1  single-cycle request to transmit the string.
REQ-011 abort  in  1  stop after the byte currently on the line.
REQ-012 tx_done  in  1  one-cycle pulse from uart_byte_tx marking end of stop bit.
REQ-013 tx_data  out  8  byte to uart_byte_tx data_byte.
REQ-014 tx_send_en  out  1  one-cycle send pulse to uart_byte_tx send_en.
REQ-015 tx_baud_set  out  3  latched baud code to uart_byte_tx baud_set.
REQ-016 busy  out  1  high from accepted start until done.
REQ-017 done  out  1  one-cycle pulse when string finished or aborted.
REQ-018 byte_idx  out  log2(DEPTH)  index of byte currently being sent.

Function
REQ-019 FSM states IDLE, FETCH, SEND, WAIT, GAP, FIN, encoded in one register.
REQ-020 IDLE: start=1 latches str_len (clamped to DEPTH) and baud_sel, clears byte_idx, goes to FETCH; if latched length is 0 goes to FIN without any tx_send_en.
REQ-021 FETCH: registers buf[byte_idx] onto tx_data, next cycle SEND (buffer read latency 1 clk).
REQ-022 SEND: tx_send_en=1 for exactly one cycle with tx_data stable, then WAIT.
REQ-023 WAIT: holds tx_data; on tx_done, if byte_idx = len-1 or abort pending go to FIN, else byte_idx+1 and GAP (or FETCH if GAP_CYCLES=0).
REQ-024 GAP: counts GAP_CYCLES clk cycles then FETCH.
REQ-025 FIN: done=1 one cycle, busy falls same cycle as done ends, return to IDLE.
REQ-026 tx_data and tx_baud_set SHALL stay constant from SEND through the matching tx_done.
REQ-027 start while busy SHALL be ignored; no queuing.
REQ-028 wr_en while busy SHALL be ignored; buffer contents locked during a transfer.
REQ-029 wr_en and start in the same IDLE cycle: write completes, start is accepted, written byte is visible to FETCH.
REQ-030 abort is sticky until FIN; abort in IDLE is ignored; abort never truncates a byte already signalled by tx_send_en.
REQ-031 tx_done outside WAIT SHALL be ignored.
REQ-032 str_len above DEPTH SHALL be clamped to DEPTH.

Reset
REQ-033 rst_n low: state IDLE, tx_send_en=0, busy=0, done=0, tx_data=0, tx_baud_set=0, byte_idx=0, gap counter 0, abort flag 0, immediately and asynchronously.
REQ-034 Buffer contents need not be reset.
REQ-035 Reset mid-transfer SHALL drop tx_send_en the same instant; no done pulse is issued.

Structure
REQ-036 Shared package uart_pkg holds state encoding and the baud-code constants also used by uart_byte_tx.
REQ-037 Buffer implemented as sub-module uart_str_buf (DEPTH x 8, one synchronous write port, one registered read port).
REQ-038 uart_byte_tx is instantiated by the parent, not inside this block.

Verification
REQ-039 Bench pairs DUT with uart_byte_tx and a line monitor at 50 MHz clk.
REQ-040 Write "HELLO" to addr 0-4, str_len=5, baud_sel=0, start -> line carries 0x48,0x45,0x4C,0x4C,0x4F in order, exactly 5 tx_send_en pulses, one done.
REQ-041 str_len=0, start -> done exactly 2 clk after start, no tx_send_en, busy high for 2 clk.
REQ-042 str_len=20 with DEPTH=16 -> exactly 16 bytes sent, byte_idx wraps to 0 only in next transfer.
REQ-043 abort asserted during byte 2 of 5 -> bytes 0-2 complete on line, byte 3 never sent, done pulses once.
REQ-044 start and wr_en during transfer -> ignored; buffer readback and byte count unchanged.
REQ-045 rst_n low during WAIT of byte 1 -> all outputs reset values immediately, next start after release transmits from byte 0.
